seq_detector_param: RTL and testbench
=====================================

// Module: seq_detector_param
// PURPOSE
//  Parametrised Mealy serial-pattern detector, successor to the fixed-pattern detector.
//  - Pattern value, pattern length and overlap mode are set per instance.
//  - Adds an input-valid qualifier and a saturating detection counter.
//  - Sits on a 1-bit serial stream; det feeds downstream framing/alignment logic.
// PARAMETERS
//  PAT_LEN   4        pattern length in bits, 1..32
//  PATTERN   4'b1101  pattern; PATTERN[PAT_LEN-1] is the first bit received, PATTERN[0] the last
//  OVERLAP   1        1: matches may share bits; 0: search restarts after each match
//  COUNT_W   8        width of det_count
// PORTS
//  clk        in   1        rising-edge clock
//  reset      in   1        asynchronous, active-high reset
//  inp        in   1        serial data bit, sampled when in_valid=1
//  in_valid   in   1        qualifies inp; when 0 the FSM holds its state
//  count_clr  in   1        synchronous clear of det_count
//  det        out  1        Mealy detect, combinational from inp/in_valid/state
//  det_count  out  COUNT_W  number of detections, saturating
//  match_len  out  SW       current state = bits matched so far, SW = max(1,$clog2(PAT_LEN))
// BEHAVIOUR
//  - Interface: one clock; reset is asynchronous and active-high.
//  - Reset: state=0, det_count=0, match_len=0. det=0 while reset is high, regardless of inp.
//  - States S0..S(PAT_LEN-1): Sk means the last k valid bits equal the first k pattern bits.
//  - det = in_valid & (state==PAT_LEN-1) & (inp==PATTERN[0]).
//  - det has zero latency: it asserts in the same cycle the final bit is presented.
//  - The state updates on the next rising edge.
//  - Expected bit in state k: PATTERN[PAT_LEN-1-k].
//  - Match on a valid bit, k<PAT_LEN-1: next state = k+1.
//  - Mismatch on a valid bit: next state = length of the longest proper pattern prefix
//    that is a suffix of (matched bits + inp).
//    The KMP-style table is computed at elaboration by a constant function; there is no runtime table.
//  - Full match: OVERLAP=1 -> next state = longest proper border of PATTERN. OVERLAP=0 -> S0.
//  - in_valid=0: state holds, det=0, det_count holds.
//  - PAT_LEN=1: the state is always S0. det = in_valid & (inp==PATTERN[0]).
//  - Out-of-range state, which is unreachable: next state = S0.
//  - Counter: increments by 1 on the edge where det=1.
//  - Counter saturates at 2^COUNT_W-1 with no wrap.
//  - Counter: count_clr=1 forces 0 on the edge and beats a simultaneous det, so that detection is not counted.
//  - count_clr does not affect the FSM.
//  - Reset asserted mid-pattern: the partial match is discarded immediately.
//  - After reset releases, a full PAT_LEN valid bits are needed for the next det.
// CONFIGURATION
//  SEQ_DET_COUNT_EN defined:
//    counter logic as described above.
//  SEQ_DET_COUNT_EN undefined:
//    det_count is tied to 0, count_clr is ignored, and no counter flops are built.
//    The port list is unchanged; det, match_len and FSM behaviour are identical.
// TESTING  (PATTERN=4'b1101, PAT_LEN=4, COUNT_W=8, SEQ_DET_COUNT_EN defined unless noted)
//  1. Reset for 1 cycle, then valid stream 1,1,0,1 -> det=1 only while the 4th bit is presented;
//     det_count=1 after that edge; match_len=1 afterwards with OVERLAP=1.
//  2. Stream 1,1,0,1,1,0,1:
//     OVERLAP=1 -> det on bits 4 and 7, det_count=2.
//     OVERLAP=0 -> det on bit 4 only, det_count=1.
//  3. Stream 1,1,0, then in_valid=0 for 3 cycles with inp toggling, then valid 1 -> det=1 on that bit.
//     match_len holds at 3 during the gap.
//  4. Stream 1,1,1,0,1 -> the mismatch fallback keeps match_len=2 after the third 1; det on the final 1.
//  5. COUNT_W=2, 5 detections -> det_count = 1,2,3,3,3.
//     count_clr pulsed in the same cycle as a det -> det_count=0.
//  6. Stream 1,1,0, then reset pulsed between edges -> match_len=0 and det=0 immediately.
//     Next valid 1 -> det=0, match_len=1.
//     With SEQ_DET_COUNT_EN undefined, rerun test 1 -> det_count stays 0.

Source files
------------

// File: rtl/seq_detector_param_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_detector_param_if
// Purpose  : Serial-stream interface for seq_detector_param. It bundles the
//            data and qualifier inputs, the counter clear, and the detector
//            outputs.
// Signals  : inp       serial data bit
//            in_valid  qualifies inp
//            count_clr synchronous clear of det_count
//            det       Mealy detect output
//            det_count saturating detection count [COUNT_W-1:0]
//            match_len current match length [SW-1:0]
// Modports : master (stream source / observer), slave (detector)
// Revision : 1.0 - initial release
// ============================================================================
interface seq_detector_param_if #(
  parameter int PAT_LEN = 4,
  parameter int COUNT_W = 8
);
  localparam int SW = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;

  logic               inp;
  logic               in_valid;
  logic               count_clr;
  logic               det;
  logic [COUNT_W-1:0] det_count;
  logic [SW-1:0]      match_len;

  modport master (
    output inp, in_valid, count_clr,
    input  det, det_count, match_len
  );

  modport slave (
    input  inp, in_valid, count_clr,
    output det, det_count, match_len
  );
endinterface
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module   : seq_detector_param
// Purpose  : Parametrised Mealy serial-pattern detector. It has a valid
//            qualifier, selectable overlap, and an optional saturating
//            detection counter.
// Ports    : clk    rising-edge clock
//            reset  asynchronous active-high reset
//            bus    seq_detector_param_if.slave (inp, in_valid, count_clr in;
//                   det, det_count, match_len out)
// Config   : SEQ_DET_COUNT_EN - when defined, the detection counter is built.
//            When undefined, det_count reads 0 and count_clr is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module seq_detector_param #(
  parameter int               PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
  parameter bit               OVERLAP = 1'b1,
  parameter int               COUNT_W = 8
) (
  input  wire logic         clk,
  input  wire logic         reset,
  seq_detector_param_if.slave bus
);
  localparam int SW = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;

  // The next-state table is indexed by {state, bit}. Each entry is the length
  // of the longest pattern prefix that ends the matched bits plus the new bit.
  // The entry never exceeds PAT_LEN-1, because a full match wraps to its
  // border (or to 0 when overlap is off).
  function automatic logic [2*PAT_LEN*SW-1:0] build_next_tbl();
    logic [2*PAT_LEN*SW-1:0] tbl;
    logic [32:0]             seq;
    int                      best;
    int                      lim;
    bit                      ok;
    tbl = '0;
    seq = '0;
    for (int k = 0; k < PAT_LEN; k++) begin
      for (int b = 0; b < 2; b++) begin
        for (int j = 0; j < k; j++) seq[j] = PATTERN[PAT_LEN-1-j];
        seq[k] = b[0];
        lim  = (k + 1 < PAT_LEN) ? k + 1 : PAT_LEN - 1;
        best = 0;
        for (int l = 1; l <= lim; l++) begin
          ok = 1'b1;
          for (int i = 0; i < l; i++)
            if (seq[k+1-l+i] != PATTERN[PAT_LEN-1-i]) ok = 1'b0;
          if (ok) best = l;
        end
        if (!OVERLAP && (k == PAT_LEN - 1) && (b[0] == PATTERN[0])) best = 0;
        tbl[(k*2+b)*SW +: SW] = SW'(best);
      end
    end
    return tbl;
  endfunction

  localparam logic [2*PAT_LEN*SW-1:0] NEXT_TBL = build_next_tbl();

  // Only the idle state is named. Other states are numeric match lengths.
  typedef enum logic [SW-1:0] {S0 = {SW{1'b0}}} state_t;

  state_t state_q, state_d;
  logic   det_w;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S0;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    det_w   = 1'b0;
    if (int'(state_q) >= PAT_LEN) begin
      state_d = S0;
    end else if (bus.in_valid) begin
      state_d = state_t'(NEXT_TBL[(int'(state_q)*2 + int'(bus.inp))*SW +: SW]);
      // The reset gate matters for PAT_LEN=1, where S0 is also the final state.
      det_w   = !reset && (int'(state_q) == PAT_LEN - 1) && (bus.inp == PATTERN[0]);
    end
  end

  assign bus.det       = det_w;
  assign bus.match_len = state_q;

`ifdef SEQ_DET_COUNT_EN
  logic [COUNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (bus.count_clr)         cnt_d = '0;   // clear wins over a same-cycle detect
    else if (det_w && ~&cnt_q) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign bus.det_count = cnt_q;
`else
  logic count_clr_unused;
  assign count_clr_unused = bus.count_clr;
  assign bus.det_count    = '0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_detector_param
// Purpose  : Directed self-checking bench for seq_detector_param. Four
//            instances share one stimulus stream:
//              u_ov : 1101, overlap on,  COUNT_W=8
//              u_no : 1101, overlap off, COUNT_W=8
//              u_c2 : 1101, overlap on,  COUNT_W=2
//              u_p1 : single-bit pattern 1
// Config   : SEQ_DET_COUNT_EN selects the expected counter values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detector_param;
`ifdef SEQ_DET_COUNT_EN
  localparam logic [31:0] CNT_MASK = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] CNT_MASK = 32'h0;
`endif

  logic clk;
  logic r_rst, r_inp, r_valid, r_clr;
  int   n_checks = 0;
  int   n_fail   = 0;

  seq_detector_param_if #(.PAT_LEN(4), .COUNT_W(8)) if_ov ();
  seq_detector_param_if #(.PAT_LEN(4), .COUNT_W(8)) if_no ();
  seq_detector_param_if #(.PAT_LEN(4), .COUNT_W(2)) if_c2 ();
  seq_detector_param_if #(.PAT_LEN(1), .COUNT_W(8)) if_p1 ();

  assign if_ov.inp = r_inp; assign if_ov.in_valid = r_valid; assign if_ov.count_clr = r_clr;
  assign if_no.inp = r_inp; assign if_no.in_valid = r_valid; assign if_no.count_clr = r_clr;
  assign if_c2.inp = r_inp; assign if_c2.in_valid = r_valid; assign if_c2.count_clr = r_clr;
  assign if_p1.inp = r_inp; assign if_p1.in_valid = r_valid; assign if_p1.count_clr = r_clr;

  seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .COUNT_W(8))
    u_ov (.clk(clk), .reset(r_rst), .bus(if_ov));
  seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .COUNT_W(8))
    u_no (.clk(clk), .reset(r_rst), .bus(if_no));
  seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .COUNT_W(2))
    u_c2 (.clk(clk), .reset(r_rst), .bus(if_c2));
  seq_detector_param #(.PAT_LEN(1), .PATTERN(1'b1), .OVERLAP(1'b1), .COUNT_W(8))
    u_p1 (.clk(clk), .reset(r_rst), .bus(if_p1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ec(input int v);
    return 32'(v) & CNT_MASK;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    r_rst = 1'b1; r_valid = 1'b0; r_inp = 1'b0; r_clr = 1'b0;
    tick();
    r_rst = 1'b0;
    #1;
  endtask

  task automatic feed(input logic b, input logic v);
    r_inp = b; r_valid = v;
    #1;
  endtask

  logic [6:0]  s2, e2_ov, e2_no;
  logic [3:0]  s1;

  initial begin
    r_rst = 1'b1; r_inp = 1'b0; r_valid = 1'b0; r_clr = 1'b0;

    // Test 1: reset state, then the basic 1101 match.
    do_reset();
    check("rst_ml",  32'(if_ov.match_len), 0);
    check("rst_cnt", 32'(if_ov.det_count), 0);
    check("rst_det", 32'(if_ov.det), 0);
    s1 = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      feed(s1[3-i], 1'b1);
      check($sformatf("t1_det_b%0d", i), 32'(if_ov.det), (i == 3) ? 1 : 0);
      check($sformatf("t1_p1det_b%0d", i), 32'(if_p1.det), 32'(s1[3-i]));
      tick();
    end
    check("t1_cnt",    32'(if_ov.det_count), ec(1));
    check("t1_ml_ov",  32'(if_ov.match_len), 1);
    check("t1_ml_no",  32'(if_no.match_len), 0);
    check("t1_p1_cnt", 32'(if_p1.det_count), ec(3));

    // Test 2: overlapping stream, with and without overlap.
    do_reset();
    s2 = 7'b1101101; e2_ov = 7'b0001001; e2_no = 7'b0001000;
    for (int i = 0; i < 7; i++) begin
      feed(s2[6-i], 1'b1);
      check($sformatf("t2_ov_det_b%0d", i), 32'(if_ov.det), 32'(e2_ov[6-i]));
      check($sformatf("t2_no_det_b%0d", i), 32'(if_no.det), 32'(e2_no[6-i]));
      tick();
    end
    check("t2_ov_cnt", 32'(if_ov.det_count), ec(2));
    check("t2_no_cnt", 32'(if_no.det_count), ec(1));

    // Test 3: an invalid gap holds the partial match.
    do_reset();
    feed(1'b1, 1'b1); tick();
    feed(1'b1, 1'b1); tick();
    feed(1'b0, 1'b1); tick();
    for (int i = 0; i < 3; i++) begin
      feed(i[0] ? 1'b0 : 1'b1, 1'b0);
      check($sformatf("t3_gap_det%0d", i),   32'(if_ov.det), 0);
      check($sformatf("t3_gap_p1det%0d", i), 32'(if_p1.det), 0);
      tick();
      check($sformatf("t3_gap_ml%0d", i), 32'(if_ov.match_len), 3);
    end
    feed(1'b1, 1'b1);
    check("t3_det", 32'(if_ov.det), 1);
    tick();

    // Test 4: mismatch fallback on 1,1,1,0,1.
    do_reset();
    feed(1'b1, 1'b1); tick();
    feed(1'b1, 1'b1); tick();
    feed(1'b1, 1'b1);
    check("t4_det_b2", 32'(if_ov.det), 0);
    tick();
    check("t4_ml_fallback", 32'(if_ov.match_len), 2);
    feed(1'b0, 1'b1); tick();
    check("t4_ml_b3", 32'(if_ov.match_len), 3);
    feed(1'b1, 1'b1);
    check("t4_det", 32'(if_ov.det), 1);
    tick();

    // Test 5: 2-bit counter saturation, then clear beating a detect.
    do_reset();
    feed(1'b1, 1'b1); tick();
    feed(1'b1, 1'b1); tick();
    feed(1'b0, 1'b1); tick();
    feed(1'b1, 1'b1); tick();
    check("t5_c2_cnt1", 32'(if_c2.det_count), ec(1));
    for (int j = 1; j <= 4; j++) begin
      feed(1'b1, 1'b1); tick();
      feed(1'b0, 1'b1); tick();
      feed(1'b1, 1'b1);
      check($sformatf("t5_c2_det%0d", j), 32'(if_c2.det), 1);
      tick();
      check($sformatf("t5_c2_cnt%0d", j + 1), 32'(if_c2.det_count), ec((j + 1 > 3) ? 3 : j + 1));
      check($sformatf("t5_ov_cnt%0d", j + 1), 32'(if_ov.det_count), ec(j + 1));
    end
    feed(1'b1, 1'b1); tick();
    feed(1'b0, 1'b1); tick();
    r_clr = 1'b1;
    feed(1'b1, 1'b1);
    check("t5_clr_det", 32'(if_ov.det), 1);
    tick();
    r_clr = 1'b0;
    check("t5_clr_c2", 32'(if_c2.det_count), 0);
    check("t5_clr_ov", 32'(if_ov.det_count), 0);
    check("t5_clr_ml", 32'(if_ov.match_len), 1);
    feed(1'b1, 1'b1); tick();
    feed(1'b0, 1'b1); tick();
    feed(1'b1, 1'b1); tick();
    check("t5_recount", 32'(if_ov.det_count), ec(1));

    // Test 6: an asynchronous reset pulse mid-pattern.
    do_reset();
    feed(1'b1, 1'b1); tick();
    feed(1'b1, 1'b1); tick();
    feed(1'b0, 1'b1); tick();
    feed(1'b1, 1'b1);
    check("t6_pre_det", 32'(if_ov.det), 1);
    r_rst = 1'b1;
    #1;
    check("t6_rst_det",   32'(if_ov.det), 0);
    check("t6_rst_ml",    32'(if_ov.match_len), 0);
    check("t6_rst_p1det", 32'(if_p1.det), 0);
    r_rst = 1'b0;
    #1;
    check("t6_post_det", 32'(if_ov.det), 0);
    tick();
    check("t6_post_ml",  32'(if_ov.match_len), 1);
    check("t6_post_cnt", 32'(if_ov.det_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    n_fail++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
